ssd_scan_driver: RTL

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_scan_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver: cycles one digit at a time from a frame snapshot.
// Optional build macro SSD_LZ_SUPPRESS_EN blanks leading zero digits (digit 0 is never suppressed).
module ssd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              g_to_a,
  output logic                    dp,
  output logic [2:0]              digit_idx
);

  localparam int                  CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]          IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]          SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic                DP_OFF   = ACTIVE_LOW;

  // Active-low segment pattern, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    lit;

  // Refresh counter, digit index and frame snapshot.
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    wrap         = tick && (idx_q == IDX_LAST);
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_data_d  = snap_data_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    if (!enable) begin
      cnt_d        = '0;
      idx_d        = '0;
      snap_data_d  = data;
      snap_dp_d    = dp_in;
      snap_blank_d = blank_in;
    end else begin
      if (tick) begin
        cnt_d = '0;
        idx_d = wrap ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Only reload at the frame boundary so a frame never mixes old and new data.
      if (wrap) begin
        snap_data_d  = data;
        snap_dp_d    = dp_in;
        snap_blank_d = blank_in;
      end
    end
  end

`ifdef SSD_LZ_SUPPRESS_EN
  logic zero_run;

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run & (snap_data_q[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Output decode for the digit currently selected.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        cur_nib   = snap_data_q[4*k +: 4];
        cur_dp    = snap_dp_q[k];
        cur_blank = snap_blank_q[k] | lz_blank[k];
        onehot[k] = 1'b1;
      end
    end
    lit  = enable && !cur_blank;
    an_d  = ~(onehot & {NUM_DIGITS{lit}}) ^ {NUM_DIGITS{~ACTIVE_LOW}};
    seg_d = (lit ? seg_decode(cur_nib) : 7'b1111111) ^ {7{~ACTIVE_LOW}};
    dp_d  = ~(lit & cur_dp) ^ ~ACTIVE_LOW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an        = an_q;
  assign g_to_a    = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule
